// File: rtl/systolic1_drain.sv
// Latches LANES accumulator words on a capture pulse and drains them one beat at a time over a valid/ready port.
// Optional build macro SYSTOLIC1_DRAIN_RELU_EN rectifies each lane (negative -> 0) at capture.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no set buffered; out_valid low, waiting for capture
// ST_DRAIN | buffered set being serialized; out_idx points at current lane

module systolic1_drain #(
    parameter int LANES = 32,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   capture,
    input  logic [LANES*WIDTH-1:0] p_bus,
    output logic [WIDTH-1:0]       out_data,
    output logic [4:0]             out_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   clr_overrun
);

    localparam logic [4:0] LAST_IDX = 5'(LANES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_buf [LANES];
    logic [WIDTH-1:0] w_lane [LANES];
    logic [4:0]       r_idx;
    logic             r_overrun;
    logic             w_xfer;
    logic             w_final;
    logic             w_accept;
    logic             w_drop;

    // A capture landing on the final transfer edge is a back-to-back set, not an overrun.
    assign w_xfer   = (r_state == ST_DRAIN) && out_ready;
    assign w_final  = w_xfer && (r_idx == LAST_IDX);
    assign w_accept = capture && ((r_state == ST_IDLE) || w_final);
    assign w_drop   = capture && (r_state == ST_DRAIN) && !w_final;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_lane[i] = p_bus[WIDTH*i +: WIDTH];
`ifdef SYSTOLIC1_DRAIN_RELU_EN
            if (w_lane[i][WIDTH-1]) begin
                w_lane[i] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (capture) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_final && !capture) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_DRAIN);
        busy      = (r_state == ST_DRAIN);
        out_idx   = r_idx;
        out_last  = (r_state == ST_DRAIN) && (r_idx == LAST_IDX);
        out_data  = (r_state == ST_DRAIN) ? r_buf[r_idx] : '0;
        overrun   = r_overrun;
    end

    // Buffer has no reset: its contents are masked whenever out_valid is low.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= w_lane;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (w_xfer) begin
            r_idx <= w_final ? 5'd0 : r_idx + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic1_drain.sv
// Scoreboard bench for systolic1_drain: stimulus pushes expected beats, a negedge monitor pops and compares.
// Honours SYSTOLIC1_DRAIN_RELU_EN when computing expected lane values.

module tb_systolic1_drain;

    localparam int LANES = 32;
    localparam int WIDTH = 32;
    localparam int BUS   = LANES * WIDTH;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             capture = 1'b0;
    logic [BUS-1:0]   p_bus = '0;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       out_idx;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             busy;
    logic             overrun;
    logic             clr_overrun = 1'b0;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    systolic1_drain #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .capture     (capture),
        .p_bus       (p_bus),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expect_lane(input logic [31:0] v);
`ifdef SYSTOLIC1_DRAIN_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [BUS-1:0] mk_bus(input logic [31:0] base, input logic [31:0] stp);
        logic [BUS-1:0] b;
        for (int i = 0; i < LANES; i++) begin
            b[32*i +: 32] = base + 32'(i) * stp;
        end
        return b;
    endfunction

    task automatic push_set(input logic [BUS-1:0] bus);
        beat_t b;
        for (int i = 0; i < LANES; i++) begin
            b.d = expect_lane(bus[32*i +: 32]);
            b.i = 5'(i);
            b.l = (i == LANES - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_capture(input logic [BUS-1:0] bus);
        p_bus   = bus;
        capture = 1'b1;
        push_set(bus);
        step();
        capture = 1'b0;
        p_bus   = '1;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 300; n++) begin
            if (!busy) break;
            step();
        end
        chk({name, " busy low"}, 32'(busy), 32'h0);
        chk({name, " queue drained"}, exp_q.size(), 32'h0);
    endtask

    task automatic wait_idx(input string name, input logic [4:0] k);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (out_valid && out_idx == k) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk({name, " reached idx"}, 32'(found), 32'h1);
    endtask

    // Monitor: pops on each accepted beat, checks hold-stability on stalled beats.
    logic        prev_stall = 1'b0;
    logic [31:0] held_d;
    logic [4:0]  held_i;
    logic        held_l;

    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (resetn && out_valid) begin
                chk("busy with valid", 32'(busy), 32'h1);
                if (prev_stall) begin
                    chk("stall data hold", out_data, held_d);
                    chk("stall idx hold", 32'(out_idx), 32'(held_i));
                    chk("stall last hold", 32'(out_last), 32'(held_l));
                end
                if (out_ready) begin
                    prev_stall = 1'b0;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected beat: got idx %0d data %h expected no beat", out_idx, out_data);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat data", out_data, b.d);
                        chk("beat idx", 32'(out_idx), 32'(b.i));
                        chk("beat last", 32'(out_last), 32'(b.l));
                    end
                end else begin
                    prev_stall = 1'b1;
                    held_d = out_data;
                    held_i = out_idx;
                    held_l = out_last;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BUS-1:0] set_a;
        logic [BUS-1:0] set_c;
        logic [BUS-1:0] set_e;
        set_a = mk_bus(32'd1, 32'd1);
        set_e = mk_bus(32'h0000_0100, 32'd3);
        set_c = set_a;
        set_c[32*5 +: 32] = 32'hFFFF_FFF6;

        #12;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_idx", 32'(out_idx), 32'h0);
        chk("reset out_last", 32'(out_last), 32'h0);
        step();
        resetn = 1'b1;
        step();

        // Ready high while idle must not produce anything.
        out_ready = 1'b1;
        step();
        step();
        chk("idle ready no valid", 32'(out_valid), 32'h0);

        // Straight drain, lane i = i+1.
        do_capture(set_a);
        chk("latency out_valid", 32'(out_valid), 32'h1);
        chk("latency out_idx", 32'(out_idx), 32'h0);
        chk("latency out_data", out_data, 32'h1);
        chk("latency busy", 32'(busy), 32'h1);
        wait_idle("straight");
        chk("straight out_data masked", out_data, 32'h0);

        // Same set with ready pattern 1,0,0,1.
        do_capture(set_a);
        for (int c = 0; c < 300; c++) begin
            if (!busy) break;
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            step();
        end
        out_ready = 1'b1;
        wait_idle("stalled");

        // Negative lane 5.
        do_capture(set_c);
        wait_idx("neg", 5'd5);
`ifdef SYSTOLIC1_DRAIN_RELU_EN
        chk("lane5 rectified", out_data, 32'h0000_0000);
`else
        chk("lane5 passthrough", out_data, 32'hFFFF_FFF6);
`endif
        wait_idle("neg");

        // Capture mid-drain is dropped and sets overrun.
        do_capture(set_a);
        wait_idx("drop", 5'd10);
        p_bus   = mk_bus(32'hA000_0000, 32'd1);
        capture = 1'b1;
        step();
        capture = 1'b0;
        p_bus   = '1;
        chk("overrun set", 32'(overrun), 32'h1);
        wait_idle("drop");
        chk("overrun sticky", 32'(overrun), 32'h1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("overrun cleared", 32'(overrun), 32'h0);

        // Dropped capture coinciding with clear: set wins.
        do_capture(set_a);
        wait_idx("setwins", 5'd3);
        capture     = 1'b1;
        clr_overrun = 1'b1;
        step();
        capture     = 1'b0;
        clr_overrun = 1'b0;
        chk("overrun set wins", 32'(overrun), 32'h1);
        wait_idle("setwins");
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("overrun cleared 2", 32'(overrun), 32'h0);

        // Capture on final transfer edge: back-to-back set.
        do_capture(set_a);
        wait_idx("b2b", 5'd31);
        chk("b2b last flag", 32'(out_last), 32'h1);
        p_bus   = set_e;
        capture = 1'b1;
        push_set(set_e);
        step();
        capture = 1'b0;
        p_bus   = '1;
        chk("b2b out_valid", 32'(out_valid), 32'h1);
        chk("b2b out_idx", 32'(out_idx), 32'h0);
        chk("b2b out_data", out_data, 32'h0000_0100);
        chk("b2b overrun", 32'(overrun), 32'h0);
        wait_idle("b2b");

        // Reset mid-drain at beat 17.
        do_capture(set_a);
        wait_idx("rst", 5'd17);
        resetn = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst out_idx", 32'(out_idx), 32'h0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst out_last", 32'(out_last), 32'h0);
        exp_q.delete();
        step();
        resetn = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
        end
        chk("post-rst no valid", 32'(out_valid), 32'h0);
        chk("post-rst busy", 32'(busy), 32'h0);

        // Recovery after reset.
        do_capture(set_e);
        wait_idle("recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
